// File: rtl/ram8_pkg.sv
// Shared definitions for the 8-entry x 32-bit RAM access controller.
package ram8_pkg;

    localparam int RAM_AW    = 3;
    localparam int RAM_DW    = 32;
    localparam int RAM_DEPTH = 8;

    // Width of the lock run counter; covers the legal MAX_LOCK range 1..15.
    localparam int LOCK_CNT_W = 4;

    // Lock ownership state: nobody owns the RAM, or requester 0/1 holds it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Convert a requester index into its one-hot grant vector.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        logic [1:0] v;
        if (idx) begin
            v = 2'b10;
        end else begin
            v = 2'b01;
        end
        return v;
    endfunction

    // Convert a one-hot-or-zero grant vector back into an index (bit 1 wins).
    function automatic logic onehot_to_idx(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/ram8_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone request is always granted,
// on contention the requester that did not win last time is granted.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    // Pick one requester; i_last names the previous winner.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram8_arbiter.sv
// Two-requester access controller for the 8 x 32 RAM. One access per cycle,
// round-robin between requesters, optional bounded lock for read-modify-write
// sequences, and a registered per-requester read return one cycle after grant.
module ram8_arbiter
    import ram8_pkg::*;
#(
    parameter int MAX_LOCK = 4,
    parameter int AW       = RAM_AW,
    parameter int DW       = RAM_DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req,
    input  logic [1:0]      we,
    input  logic [1:0]      lock,
    input  logic [2*AW-1:0] addr,
    input  logic [2*DW-1:0] wdata,
    output logic [1:0]      gnt,
    output logic [1:0]      rvalid,
    output logic [2*DW-1:0] rdata,
    output logic            ram_en,
    output logic            ram_write,
    output logic [AW-1:0]   ram_address,
    output logic [DW-1:0]   ram_in,
    input  logic [DW-1:0]   ram_out
);

    // Lock run limit in counter width.
    localparam logic [LOCK_CNT_W-1:0] LOCK_LIMIT = LOCK_CNT_W'(MAX_LOCK);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic                    r_last;
    logic                    w_last_nxt;
    logic [LOCK_CNT_W-1:0]   r_lock_cnt;
    logic [LOCK_CNT_W-1:0]   w_lock_cnt_nxt;

    logic [1:0]              w_pick;
    logic [1:0]              w_arb_gnt;
    logic [1:0]              w_gnt;
    logic                    w_any;
    logic                    w_sel;
    logic                    w_owner;
    logic                    w_other;
    logic                    w_sel_we;
    logic [AW-1:0]           w_sel_addr;
    logic [DW-1:0]           w_sel_wdata;
    logic [1:0]              w_rd_take;

    logic [1:0]              r_rvalid;
    logic [2*DW-1:0]         r_rdata;

    // While idle, the round-robin picker decides contention.
    rr_pick2 u_pick (
        .i_req  (req),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    // In a LOCK state the owner is the requester named by the state.
    assign w_owner = (r_state == LOCK1);
    assign w_other = ~w_owner;

    // Grant decision: round-robin when idle; when locked the owner keeps the
    // RAM unless its run has reached the limit and the other side is waiting.
    // An owner that drops its request leaves a one-cycle bubble.
    always_comb begin
        w_arb_gnt = 2'b00;
        case (r_state)
            IDLE: begin
                w_arb_gnt = w_pick;
            end
            LOCK0, LOCK1: begin
                if (!req[w_owner]) begin
                    w_arb_gnt = 2'b00;
                end else if ((r_lock_cnt >= LOCK_LIMIT) && req[w_other]) begin
                    w_arb_gnt = idx_to_onehot(w_other);
                end else begin
                    w_arb_gnt = idx_to_onehot(w_owner);
                end
            end
            default: begin
                w_arb_gnt = 2'b00;
            end
        endcase
    end

    // Reset forces the grant (and therefore the RAM strobes) low immediately.
    assign w_gnt = reset ? 2'b00 : w_arb_gnt;
    assign w_any = |w_gnt;
    assign w_sel = onehot_to_idx(w_gnt);

    // Steer the granted requester's command fields onto the RAM pins.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = {AW{1'b0}};
        w_sel_wdata = {DW{1'b0}};
        if (w_sel) begin
            w_sel_we    = we[1];
            w_sel_addr  = addr[2*AW-1:AW];
            w_sel_wdata = wdata[2*DW-1:DW];
        end else begin
            w_sel_we    = we[0];
            w_sel_addr  = addr[AW-1:0];
            w_sel_wdata = wdata[DW-1:0];
        end
    end

    assign gnt         = w_gnt;
    assign ram_en      = w_any;
    assign ram_write   = w_any & w_sel_we;
    assign ram_address = w_any ? w_sel_addr  : {AW{1'b0}};
    assign ram_in      = w_any ? w_sel_wdata : {DW{1'b0}};

    // Next ownership state, lock run count and last winner.
    always_comb begin
        w_state_nxt    = IDLE;
        w_lock_cnt_nxt = {LOCK_CNT_W{1'b0}};
        if (w_any) begin
            w_last_nxt = w_sel;
        end else begin
            w_last_nxt = r_last;
        end
        case (r_state)
            IDLE: begin
                if (w_any && lock[w_sel]) begin
                    w_state_nxt    = w_sel ? LOCK1 : LOCK0;
                    w_lock_cnt_nxt = {{(LOCK_CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    w_state_nxt    = IDLE;
                    w_lock_cnt_nxt = {LOCK_CNT_W{1'b0}};
                end
            end
            LOCK0, LOCK1: begin
                // Ownership continues only on a locked grant to the owner;
                // the count saturates so an unopposed owner keeps the RAM.
                if (w_any && (w_sel == w_owner) && lock[w_owner]) begin
                    w_state_nxt = r_state;
                    if (r_lock_cnt >= LOCK_LIMIT) begin
                        w_lock_cnt_nxt = LOCK_LIMIT;
                    end else begin
                        w_lock_cnt_nxt = r_lock_cnt + {{(LOCK_CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_state_nxt    = IDLE;
                    w_lock_cnt_nxt = {LOCK_CNT_W{1'b0}};
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_lock_cnt_nxt = {LOCK_CNT_W{1'b0}};
            end
        endcase
    end

    // Arbitration state registers; last starts at 1 so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_lock_cnt <= {LOCK_CNT_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // A granted read captures the RAM output at the edge ending its cycle.
    assign w_rd_take = w_gnt & ~we;

    // Read return: rvalid pulses one cycle, rdata holds until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rvalid <= 2'b00;
            r_rdata  <= {(2*DW){1'b0}};
        end else begin
            r_rvalid <= w_rd_take;
            if (w_rd_take[0]) begin
                r_rdata[DW-1:0] <= ram_out;
            end
            if (w_rd_take[1]) begin
                r_rdata[2*DW-1:DW] <= ram_out;
            end
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Self-checking bench for ram8_arbiter: directed scenarios plus a randomized
// run, all compared against a behavioural model of the grant rules and RAM.
module tb_ram8_arbiter;

    localparam int MAXL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, we, lock;
    logic [5:0]  addr;
    logic [63:0] wdata;
    logic [1:0]  gnt, rvalid;
    logic [63:0] rdata;
    logic        ram_en, ram_write;
    logic [2:0]  ram_address;
    logic [31:0] ram_in, ram_out;

    int checks   = 0;
    int failures = 0;

    // RAM behind the arbiter (registered write, enable-gated combinational read)
    logic [31:0] ram_mem [8] = '{32'h1000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                                 32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};
    // Model's view of the same RAM
    logic [31:0] ref_mem [8] = '{32'h1000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                                 32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};

    // Model state: owner (-1 = nobody), length of the locked run, last winner
    int m_owner, m_held, m_last;
    // Model expectations for the current cycle and for the registered outputs
    int          e_g;
    logic [1:0]  e_gnt;
    logic        e_en, e_wr;
    logic [2:0]  e_addr;
    logic [31:0] e_in, e_rd;
    logic [1:0]  e_rvalid;
    logic [31:0] e_rdata [2];

    ram8_arbiter #(.MAX_LOCK(MAXL)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_en(ram_en), .ram_write(ram_write), .ram_address(ram_address),
        .ram_in(ram_in), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    assign ram_out = ram_en ? ram_mem[ram_address] : 32'd0;
    always @(posedge clk) if (ram_en && ram_write) ram_mem[ram_address] <= ram_in;

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_last = 1;
        e_rvalid = 2'b00; e_rdata[0] = 32'd0; e_rdata[1] = 32'd0;
    endtask

    // Expected grant and RAM pins from the arbitration rules.
    task automatic model_comb();
        int o;
        e_g = -1;
        if (m_owner < 0) begin
            if (req == 2'b01) e_g = 0;
            else if (req == 2'b10) e_g = 1;
            else if (req == 2'b11) e_g = 1 - m_last;
        end else begin
            o = m_owner;
            if (req[o]) e_g = (m_held >= MAXL && req[1-o]) ? 1 - o : o;
        end
        if (reset) e_g = -1;
        e_gnt  = (e_g < 0) ? 2'b00 : ((e_g == 0) ? 2'b01 : 2'b10);
        e_en   = (e_g >= 0);
        e_wr   = (e_g >= 0) && we[e_g];
        e_addr = (e_g >= 0) ? addr[3*e_g +: 3] : 3'd0;
        e_in   = (e_g >= 0) ? wdata[32*e_g +: 32] : 32'd0;
        e_rd   = (e_g >= 0) ? ref_mem[e_addr] : 32'd0;
    endtask

    // Effects of the clock edge that ends the current cycle.
    task automatic model_edge();
        if (e_g >= 0 && e_wr) ref_mem[e_addr] = e_in;
        e_rvalid = 2'b00;
        if (e_g >= 0 && !e_wr) begin
            e_rvalid[e_g] = 1'b1;
            e_rdata[e_g]  = e_rd;
        end
        if (e_g >= 0) begin
            if (m_owner < 0) begin
                if (lock[e_g]) begin m_owner = e_g; m_held = 1; end
            end else if (e_g == m_owner && lock[e_g]) begin
                m_held = (m_held < MAXL) ? m_held + 1 : MAXL;
            end else begin
                m_owner = -1; m_held = 0;
            end
            m_last = e_g;
        end else begin
            m_owner = -1; m_held = 0;
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                         input logic [2:0] a0, input logic [2:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req = r; we = w; lock = l; addr = {a1, a0}; wdata = {d1, d0};
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        drive(2'b11, 2'b11, 2'b00, 3'd1, 3'd2, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
        checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL rst_gnt: got %b want 00", gnt); end
        checks++; if (ram_en !== 1'b0 || ram_write !== 1'b0) begin failures++; $display("FAIL rst_ram: en=%b wr=%b want 0 0", ram_en, ram_write); end
        checks++; if (ram_address !== 3'd0 || ram_in !== 32'd0) begin failures++; $display("FAIL rst_pins: addr=%0d in=%h want 0 0", ram_address, ram_in); end
        tick();
        checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL rst_rvalid: got %b want 00", rvalid); end
        checks++; if (rdata !== 64'd0) begin failures++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_write_read();
        drive(2'b01, 2'b01, 2'b00, 3'd5, 3'd0, 32'hDEAD_BEEF, 32'd0);
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL wr_gnt: got %b want 01", gnt); end
        checks++; if (ram_write !== 1'b1 || ram_address !== 3'd5 || ram_in !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL wr_pins: wr=%b addr=%0d in=%h want 1 5 deadbeef", ram_write, ram_address, ram_in); end
        tick();
        checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL wr_rvalid: got %b want 00", rvalid); end
        drive(2'b01, 2'b00, 2'b00, 3'd5, 3'd0, 32'd0, 32'd0);
        checks++; if (gnt !== 2'b01 || ram_write !== 1'b0) begin failures++; $display("FAIL rd_gnt: gnt=%b wr=%b want 01 0", gnt, ram_write); end
        tick();
        checks++; if (rvalid !== 2'b01) begin failures++; $display("FAIL rd_rvalid: got %b want 01", rvalid); end
        checks++; if (rdata[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_rdata: got %h want deadbeef", rdata[31:0]); end
        drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 32'd0, 32'd0);
        checks++; if (ram_en !== 1'b0 || gnt !== 2'b00) begin failures++; $display("FAIL idle_en: en=%b gnt=%b want 0 00", ram_en, gnt); end
        tick();
        checks++; if (rvalid !== 2'b00 || rdata[31:0] !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL rd_hold: rvalid=%b rdata0=%h want 00 deadbeef", rvalid, rdata[31:0]); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [1:0] prev;
        apply_reset();
        prev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 2'b00, 2'b00, 3'd1, 3'd6, 32'd0, 32'd0);
            checks++; if (gnt !== seq[k]) begin failures++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, seq[k]); end
            checks++; if (rvalid !== prev) begin failures++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, rvalid, prev); end
            prev = seq[k];
            tick();
        end
        checks++; if (rvalid !== 2'b10 || rdata !== {ref_mem[6], ref_mem[1]}) begin
            failures++; $display("FAIL rr_rdata: rvalid=%b rdata=%h want 10 %h", rvalid, rdata, {ref_mem[6], ref_mem[1]}); end
    endtask

    task automatic test_lock_limit();
        logic [1:0] seq [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, 2'b00, 2'b01, 3'd3, 3'd4, 32'd0, 32'd0);
            checks++; if (gnt !== seq[k]) begin failures++; $display("FAIL lock_gnt[%0d]: got %b want %b", k, gnt, seq[k]); end
            tick();
            checks++; if (rvalid !== seq[k]) begin failures++; $display("FAIL lock_rvalid[%0d]: got %b want %b", k, rvalid, seq[k]); end
        end
    endtask

    task automatic test_lock_drop();
        apply_reset();
        drive(2'b01, 2'b00, 2'b01, 3'd0, 3'd0, 32'd0, 32'd0);
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL drop_first: got %b want 01", gnt); end
        tick();
        drive(2'b10, 2'b00, 2'b00, 3'd0, 3'd3, 32'd0, 32'd0);
        checks++; if (gnt !== 2'b00 || ram_en !== 1'b0) begin failures++; $display("FAIL drop_bubble: gnt=%b en=%b want 00 0", gnt, ram_en); end
        tick();
        drive(2'b10, 2'b00, 2'b00, 3'd0, 3'd3, 32'd0, 32'd0);
        checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL drop_after: got %b want 10", gnt); end
        tick();
    endtask

    task automatic test_read_after_write();
        apply_reset();
        drive(2'b01, 2'b01, 2'b00, 3'd2, 3'd0, 32'h0000_0001, 32'd0);
        checks++; if (gnt !== 2'b01 || ram_write !== 1'b1) begin failures++; $display("FAIL raw_wr: gnt=%b wr=%b want 01 1", gnt, ram_write); end
        tick();
        drive(2'b10, 2'b00, 2'b00, 3'd0, 3'd2, 32'd0, 32'd0);
        checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL raw_gnt: got %b want 10", gnt); end
        tick();
        checks++; if (rvalid !== 2'b10 || rdata[63:32] !== 32'h0000_0001) begin
            failures++; $display("FAIL raw_data: rvalid=%b rdata1=%h want 10 00000001", rvalid, rdata[63:32]); end
        drive(2'b00, 2'b11, 2'b00, 3'd2, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (ram_en !== 1'b0 || ram_write !== 1'b0) begin failures++; $display("FAIL raw_idle: en=%b wr=%b want 0 0", ram_en, ram_write); end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(2'b01, 2'b00, 2'b00, 3'd5, 3'd0, 32'd0, 32'd0);
        tick();
        drive(2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 32'd0, 32'd0);
        checks++; if (gnt !== 2'b01 || rvalid !== 2'b01) begin failures++; $display("FAIL mid_pre: gnt=%b rvalid=%b want 01 01", gnt, rvalid); end
        #1 reset = 1'b1;
        #1;
        checks++; if (gnt !== 2'b00 || rvalid !== 2'b00 || ram_en !== 1'b0) begin
            failures++; $display("FAIL mid_drop: gnt=%b rvalid=%b en=%b want 00 00 0", gnt, rvalid, ram_en); end
        @(posedge clk);
        #1;
        checks++; if (rvalid !== 2'b00) begin failures++; $display("FAIL mid_norv: got %b want 00", rvalid); end
        reset = 1'b0;
        model_reset();
        drive(2'b10, 2'b10, 2'b00, 3'd0, 3'd7, 32'd0, 32'hCAFE_F00D);
        checks++; if (gnt !== 2'b10 || ram_write !== 1'b1) begin failures++; $display("FAIL mid_wr: gnt=%b wr=%b want 10 1", gnt, ram_write); end
        #1 reset = 1'b1;
        #1;
        checks++; if (ram_write !== 1'b0) begin failures++; $display("FAIL mid_wr_drop: got %b want 0", ram_write); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        drive(2'b11, 2'b00, 2'b00, 3'd7, 3'd7, 32'd0, 32'd0);
        checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL mid_first: got %b want 01", gnt); end
        tick();
        checks++; if (rvalid !== 2'b01 || rdata[31:0] !== e_rdata[0] || rdata[31:0] === 32'hCAFE_F00D) begin
            failures++; $display("FAIL mid_nocommit: rvalid=%b rdata0=%h want 01 %h", rvalid, rdata[31:0], e_rdata[0]); end
    endtask

    task automatic test_random();
        logic [1:0]  hold, r, w, l;
        logic [2:0]  a [2];
        logic [31:0] d [2];
        apply_reset();
        hold = 2'b00; r = 2'b00; w = 2'b00;
        a[0] = 3'd0; a[1] = 3'd0; d[0] = 32'd0; d[1] = 32'd0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!hold[i]) begin
                    r[i] = ($urandom_range(3, 0) != 0);
                    w[i] = 1'($urandom_range(1, 0));
                    a[i] = 3'($urandom_range(7, 0));
                    d[i] = $urandom;
                end
            end
            l = 2'($urandom_range(3, 0));
            drive(r, w, l, a[0], a[1], d[0], d[1]);
            checks++; if (gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, e_gnt); end
            checks++; if (ram_en !== e_en || ram_write !== e_wr || ram_address !== e_addr || ram_in !== e_in) begin
                failures++; $display("FAIL rnd_pins c%0d: en=%b wr=%b a=%0d in=%h want %b %b %0d %h",
                                     c, ram_en, ram_write, ram_address, ram_in, e_en, e_wr, e_addr, e_in); end
            hold = r & ~e_gnt;
            tick();
            checks++; if (rvalid !== e_rvalid) begin failures++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, rvalid, e_rvalid); end
            checks++; if (rdata !== {e_rdata[1], e_rdata[0]}) begin
                failures++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata, {e_rdata[1], e_rdata[0]}); end
        end
    endtask

    initial begin
        reset = 1'b1;
        req = 2'b00; we = 2'b00; lock = 2'b00; addr = 6'd0; wdata = 64'd0;
        model_reset();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_lock_limit();
        test_lock_drop();
        test_read_after_write();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
